// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the multi-camera OV7670 capture front-end.
// Colour-bar table is only referenced when MULTI_CAM_CAPTURE_TEST_PATTERN_EN is defined.
package cam_capture_pkg;

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} cap_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // YUV422 words {Y, U/V}: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_yuv(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_yuv = 16'hEB80;
            3'd1:    bar_yuv = 16'hD292;
            3'd2:    bar_yuv = 16'hAA10;
            3'd3:    bar_yuv = 16'h9136;
            3'd4:    bar_yuv = 16'h6ADE;
            3'd5:    bar_yuv = 16'h515A;
            3'd6:    bar_yuv = 16'h29F0;
            default: bar_yuv = 16'h1080;
        endcase
    endfunction

endpackage

// File: rtl/cam_channel_capture.sv
// One camera channel: pin synchronisers, edge detect, capture FSM, geometry counters, sticky error.
// MULTI_CAM_CAPTURE_TEST_PATTERN_EN enables tp_en colour-bar substitution of pixel data.
module cam_channel_capture
    import cam_capture_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pclk,
    input  logic                href,
    input  logic                vsync,
    input  logic [DATA_W-1:0]   din,
    input  logic                byte_swap,
    input  logic                tp_en,
    input  logic                clr_err,
    output logic [2*DATA_W-1:0] pix_data,
    output logic                pix_valid,
    output logic                active_video,
    output logic                hblank,
    output logic                hsync,
    output logic                vblank,
    output logic                vid_vsync,
    output logic [CNT_W-1:0]    line_cnt,
    output logic                frame_err
);

    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);

    // [0]=s1, [1]=s2, [2]=s3; vsync chain resets low so a lock needs a real high->low
    logic [2:0]        pclk_s, href_s, vs_s;
    logic [DATA_W-1:0] din_s1, din_s2, din_e;
    logic              e_prise, e_hrise, e_hfall, e_vrise, e_vfall, e_href, e_vs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pclk_s  <= '0;
            href_s  <= '0;
            vs_s    <= '0;
            din_s1  <= '0;
            din_s2  <= '0;
            din_e   <= '0;
            e_prise <= 1'b0;
            e_hrise <= 1'b0;
            e_hfall <= 1'b0;
            e_vrise <= 1'b0;
            e_vfall <= 1'b0;
            e_href  <= 1'b0;
            e_vs    <= 1'b1;
        end else begin
            pclk_s  <= {pclk_s[1:0], pclk};
            href_s  <= {href_s[1:0], href};
            vs_s    <= {vs_s[1:0], vsync};
            din_s1  <= din;
            din_s2  <= din_s1;
            din_e   <= din_s2;
            e_prise <= pclk_s[1] & ~pclk_s[2];
            e_hrise <= href_s[1] & ~href_s[2];
            e_hfall <= ~href_s[1] & href_s[2];
            e_vrise <= vs_s[1] & ~vs_s[2];
            e_vfall <= ~vs_s[1] & vs_s[2];
            e_href  <= href_s[1];
            e_vs    <= vs_s[1];
        end
    end

    cap_state_t          state;
    logic                locked;
    logic [CNT_W-1:0]    pix_cnt;
    logic [DATA_W-1:0]   hi_byte;
    logic [2*DATA_W-1:0] word;
    logic                err_set;

    always_comb begin
        word = byte_swap ? {din_e, hi_byte} : {hi_byte, din_e};
`ifdef MULTI_CAM_CAPTURE_TEST_PATTERN_EN
        if (tp_en) word = (2*DATA_W)'(bar_yuv(pix_cnt[8:6]));
`endif
    end

`ifndef MULTI_CAM_CAPTURE_TEST_PATTERN_EN
    logic unused_tp_en;
    assign unused_tp_en = tp_en;
`endif

    // Frame check is skipped when no line was counted since lock (line_cnt still 0)
    always_comb begin
        err_set = 1'b0;
        if (e_vrise)
            err_set = locked && (line_cnt != '0) && (line_cnt != V_EXP);
        else if (!e_vfall && e_hfall && state != WAIT_FRAME)
            err_set = (pix_cnt != H_EXP) || (state == BYTE_LO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= WAIT_FRAME;
            locked       <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            hi_byte      <= '0;
            pix_data     <= '0;
            pix_valid    <= 1'b0;
            hsync        <= 1'b0;
            active_video <= 1'b0;
            hblank       <= 1'b1;
            vblank       <= 1'b1;
            vid_vsync    <= 1'b1;
            frame_err    <= 1'b0;
        end else begin
            pix_valid    <= 1'b0;
            hsync        <= 1'b0;
            active_video <= locked & e_href;
            hblank       <= ~(locked & e_href);
            vblank       <= e_vs;
            vid_vsync    <= e_vs;
            frame_err    <= err_set | (frame_err & ~clr_err);
            if (e_vrise) begin
                state <= WAIT_FRAME;
            end else if (e_vfall) begin
                state    <= WAIT_LINE;
                locked   <= 1'b1;
                line_cnt <= '0;
                pix_cnt  <= '0;
            end else if (e_hfall && state != WAIT_FRAME) begin
                state    <= WAIT_LINE;
                hsync    <= 1'b1;
                pix_cnt  <= '0;
                line_cnt <= (line_cnt == {CNT_W{1'b1}}) ? line_cnt : line_cnt + 1'b1;
            end else begin
                case (state)
                    WAIT_LINE: if (e_hrise) state <= BYTE_HI;
                    BYTE_HI: if (e_prise && e_href) begin
                        hi_byte <= din_e;
                        state   <= BYTE_LO;
                    end
                    BYTE_LO: if (e_prise && e_href) begin
                        pix_data  <= word;
                        pix_valid <= 1'b1;
                        pix_cnt   <= (pix_cnt == {CNT_W{1'b1}}) ? pix_cnt : pix_cnt + 1'b1;
                        state     <= BYTE_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_cam_capture.sv
// N-channel OV7670 capture front-end: slices pin buses into independent channel instances.
// MULTI_CAM_CAPTURE_TEST_PATTERN_EN enables the tp_en colour-bar pattern in every channel.
module multi_cam_capture
    import cam_capture_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          pclk,
    input  logic [NUM_CH-1:0]          href,
    input  logic [NUM_CH-1:0]          vsync,
    input  logic [NUM_CH*DATA_W-1:0]   din,
    input  logic                       byte_swap,
    input  logic                       tp_en,
    input  logic                       clr_err,
    output logic [NUM_CH*2*DATA_W-1:0] pix_data,
    output logic [NUM_CH-1:0]          pix_valid,
    output logic [NUM_CH-1:0]          active_video,
    output logic [NUM_CH-1:0]          hblank,
    output logic [NUM_CH-1:0]          hsync,
    output logic [NUM_CH-1:0]          vblank,
    output logic [NUM_CH-1:0]          vid_vsync,
    output logic [NUM_CH*CNT_W-1:0]    line_cnt,
    output logic [NUM_CH-1:0]          frame_err
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cam_channel_capture #(
            .DATA_W  (DATA_W),
            .H_ACTIVE(H_ACTIVE),
            .V_ACTIVE(V_ACTIVE),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .pclk        (pclk[g]),
            .href        (href[g]),
            .vsync       (vsync[g]),
            .din         (din[g*DATA_W +: DATA_W]),
            .byte_swap   (byte_swap),
            .tp_en       (tp_en),
            .clr_err     (clr_err),
            .pix_data    (pix_data[g*2*DATA_W +: 2*DATA_W]),
            .pix_valid   (pix_valid[g]),
            .active_video(active_video[g]),
            .hblank      (hblank[g]),
            .hsync       (hsync[g]),
            .vblank      (vblank[g]),
            .vid_vsync   (vid_vsync[g]),
            .line_cnt    (line_cnt[g*CNT_W +: CNT_W]),
            .frame_err   (frame_err[g])
        );
    end

endmodule

// File: tb/tb_multi_cam_capture.sv
// Scoreboard bench for multi_cam_capture with reduced frame geometry (16 px x 4 lines).
module tb_multi_cam_capture;

    localparam int NUM_CH = 2;
    localparam int H = 16;
    localparam int V = 4;
    localparam int CW = 12;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_CH-1:0]   pclk, href, vsync;
    logic [NUM_CH*8-1:0] din;
    logic                byte_swap, tp_en, clr_err;
    logic [NUM_CH*16-1:0] pix_data;
    logic [NUM_CH-1:0]   pix_valid, active_video, hblank, hsync, vblank, vid_vsync, frame_err;
    logic [NUM_CH*CW-1:0] line_cnt;

    multi_cam_capture #(.NUM_CH(NUM_CH), .DATA_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pclk(pclk), .href(href), .vsync(vsync), .din(din),
        .byte_swap(byte_swap), .tp_en(tp_en), .clr_err(clr_err),
        .pix_data(pix_data), .pix_valid(pix_valid), .active_video(active_video),
        .hblank(hblank), .hsync(hsync), .vblank(vblank), .vid_vsync(vid_vsync),
        .line_cnt(line_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pv_cnt [NUM_CH];
    int hs_cnt [NUM_CH];
    logic [NUM_CH-1:0] hs_prev = '0;
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [15:0] w);
        if (ch == 0) exp_q0.push_back(w);
        else         exp_q1.push_back(w);
    endtask

    task automatic chk_pop(input int ch);
        logic [15:0] act, e;
        act = pix_data[ch*16 +: 16];
        if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL pix_unexpected ch%0d actual=%h required=none", ch, act);
        end else begin
            if (ch == 0) e = exp_q0.pop_front();
            else         e = exp_q1.pop_front();
            check($sformatf("pix_ch%0d", ch), {16'h0, act}, {16'h0, e});
        end
    endtask

    // Monitor: pops expected pixels and checks hsync pulse width
    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            pv_cnt[c] = 0;
            hs_cnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (pix_valid[c]) begin
                        pv_cnt[c]++;
                        chk_pop(c);
                    end
                    if (hsync[c]) begin
                        hs_cnt[c]++;
                        check($sformatf("hsync_width_ch%0d", c), {31'h0, hs_prev[c]}, 32'h0);
                    end
                end
                hs_prev = hsync;
            end
        end
    end

    // Camera bytes: data changes with pclk low, expectation pushed before the second byte's rise
    task automatic cam_bytes(input int ch, input int n, input logic [7:0] a, input logic [7:0] b,
                             input bit swap, input bit exp);
        for (int i = 0; i < n; i++) begin
            din[ch*8 +: 8] = (i % 2 == 0) ? a : b;
            if (exp && (i % 2 == 1)) push(ch, swap ? {b, a} : {a, b});
            #40 pclk[ch] = 1'b1;
            #40 pclk[ch] = 1'b0;
        end
    endtask

    task automatic cam_line(input int ch, input int n, input logic [7:0] a, input logic [7:0] b,
                            input bit swap);
        href[ch] = 1'b1;
        #80;
        cam_bytes(ch, n, a, b, swap, 1'b1);
        href[ch] = 1'b0;
        #160;
    endtask

    task automatic cam_frame(input int ch, input int bad_line, input int bad_bytes,
                             input logic [7:0] a, input logic [7:0] b, input bit swap);
        vsync[ch] = 1'b1;
        #400;
        vsync[ch] = 1'b0;
        #400;
        for (int l = 0; l < V; l++)
            cam_line(ch, (l == bad_line) ? bad_bytes : 2*H, a, b, swap);
        vsync[ch] = 1'b1;
        #400;
    endtask

    int hs0, pv0;

    initial begin
        reset = 1'b0;
        pclk = '0; href = '0; vsync = '1; din = '0;
        byte_swap = 1'b0; tp_en = 1'b0; clr_err = 1'b0;
        #22;
        check("rst_pix_valid", {30'h0, pix_valid}, 32'h0);
        check("rst_active_video", {30'h0, active_video}, 32'h0);
        check("rst_hblank", {30'h0, hblank}, 32'h3);
        check("rst_vblank", {30'h0, vblank}, 32'h3);
        check("rst_vsync", {30'h0, vid_vsync}, 32'h3);
        check("rst_line_cnt", {8'h0, line_cnt}, 32'h0);
        check("rst_frame_err", {30'h0, frame_err}, 32'h0);
        #21 reset = 1'b1;
        #100;

        // Clean frame, byte_swap=0
        hs0 = hs_cnt[0]; pv0 = pv_cnt[0];
        cam_frame(0, -1, 0, 8'hA5, 8'h3C, 1'b0);
        check("a_hsync_count", hs_cnt[0] - hs0, V);
        check("a_pix_count", pv_cnt[0] - pv0, H*V);
        check("a_line_cnt", {20'h0, line_cnt[CW-1:0]}, V);
        check("a_frame_err", {30'h0, frame_err}, 32'h0);

        // Clean frame, byte_swap=1
        byte_swap = 1'b1;
        hs0 = hs_cnt[0]; pv0 = pv_cnt[0];
        cam_frame(0, -1, 0, 8'hA5, 8'h3C, 1'b1);
        check("b_hsync_count", hs_cnt[0] - hs0, V);
        check("b_pix_count", pv_cnt[0] - pv0, H*V);
        check("b_frame_err", {30'h0, frame_err}, 32'h0);
        byte_swap = 1'b0;

        // Short line (15 px) sets error; clr_err clears; clean frame keeps it clear
        cam_frame(0, 2, 2*H-2, 8'h12, 8'h34, 1'b0);
        check("c_frame_err_set", {30'h0, frame_err}, 32'h1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        check("c_frame_err_clr", {30'h0, frame_err}, 32'h0);
        cam_frame(0, -1, 0, 8'h56, 8'h78, 1'b0);
        check("c_frame_err_clean", {30'h0, frame_err}, 32'h0);

        // Odd byte count on ch0 while ch1 runs a clean frame
        fork
            cam_frame(0, 1, 2*H+1, 8'h9A, 8'hBC, 1'b0);
            cam_frame(1, -1, 0, 8'h11, 8'h22, 1'b0);
        join
        check("d_frame_err", {30'h0, frame_err}, 32'h1);
        check("d_line_cnt_ch1", {20'h0, line_cnt[2*CW-1:CW]}, V);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;

        // Reset mid-line: outputs snap to reset values, no capture until next vsync fall
        vsync[0] = 1'b1; #400; vsync[0] = 1'b0; #400;
        href[0] = 1'b1; #80;
        cam_bytes(0, 8, 8'hC3, 8'h5A, 1'b0, 1'b1);
        #200;
        reset = 1'b0;
        #1;
        check("e_rst_active_video", {30'h0, active_video}, 32'h0);
        check("e_rst_hblank", {30'h0, hblank}, 32'h3);
        check("e_rst_vblank", {30'h0, vblank}, 32'h3);
        check("e_rst_line_cnt", {8'h0, line_cnt}, 32'h0);
        #30 reset = 1'b1;
        pv0 = pv_cnt[0]; hs0 = hs_cnt[0];
        cam_bytes(0, 8, 8'hC3, 8'h5A, 1'b0, 1'b0);
        href[0] = 1'b0;
        #400;
        check("e_no_pix_after_reset", pv_cnt[0] - pv0, 0);
        check("e_no_hsync_after_reset", hs_cnt[0] - hs0, 0);
        pv0 = pv_cnt[0];
        cam_frame(0, -1, 0, 8'hA5, 8'h3C, 1'b0);
        check("e_pix_count_relock", pv_cnt[0] - pv0, H*V);
        check("e_frame_err", {30'h0, frame_err}, 32'h0);

        #200;
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
